// File: rtl/riscv_consts_pkg.sv
// Constants shared across the RV32I pipeline slice: canonical NOP,
// PCSel encodings driven by the X-stage control, and the fetch FSM states.
package riscv_consts;

  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  localparam logic [1:0]  PCSEL_PLUS4    = 2'd0;
  localparam logic [1:0]  PCSEL_REDIRECT = 2'd1;
  localparam logic [1:0]  PCSEL_RESET    = 2'd2;

  typedef enum logic [1:0] {
    FETCH_FILL = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: drives a 1-cycle synchronous IMEM and presents {pc, inst, valid} to decode.
// Fetch at t reaches decode at t+1; redirects squash two slots; stall holds the decode view.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = riscv_consts::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] redirect_tgt,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_dout,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic        D_valid,
  output logic        flush_D
);
  import riscv_consts::*;

  fetch_state_e r_state;
  logic [31:0]  r_pc_q;
  logic [31:0]  r_pc_d;
  logic [31:0]  r_hold_inst;
  logic         r_stall_q;

  logic         w_sel_reset;
  logic         w_sel_redirect;

  // pc_sel == 3 decodes as neither, so it falls through to PC+4.
  assign w_sel_reset    = (pc_sel == PCSEL_RESET);
  assign w_sel_redirect = (pc_sel == PCSEL_REDIRECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_q      <= RESET_PC;
      r_pc_d      <= RESET_PC;
      r_state     <= FETCH_FILL;
      r_stall_q   <= 1'b0;
      r_hold_inst <= NOP_INST;
    end else begin
      if (stall) begin
        r_hold_inst <= D_inst;
      end
      if (w_sel_reset) begin
        r_pc_q    <= RESET_PC;
        r_state   <= FETCH_FILL;
        r_stall_q <= 1'b0;
      end else if (w_sel_redirect) begin
        // Redirect beats stall; clearing stall_q keeps stale hold data out of the new path.
        r_pc_q    <= redirect_tgt;
        r_state   <= FETCH_KILL;
        r_stall_q <= 1'b0;
      end else if (stall) begin
        r_stall_q <= 1'b1;
      end else begin
        r_pc_d    <= r_pc_q;
        r_pc_q    <= r_pc_q + 32'd4;
        r_state   <= FETCH_RUN;
        r_stall_q <= 1'b0;
      end
    end
  end

  always_comb begin
    D_inst  = NOP_INST;
    D_valid = 1'b0;
    if (!reset && (r_state == FETCH_RUN)) begin
      D_valid = 1'b1;
      // While stalled the IMEM re-reads pc_q, not pc_d, so the held copy is what decode must see.
      D_inst  = r_stall_q ? r_hold_inst : imem_dout;
    end
  end

  assign imem_addr = r_pc_q;
  assign imem_re   = !reset;
  assign D_pc      = r_pc_d;
  assign flush_D   = (w_sel_redirect || w_sel_reset) && !reset;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit against an address-tagged synchronous IMEM model.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] redirect_tgt;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_dout;
  logic [31:0] D_pc;
  logic [31:0] D_inst;
  logic        D_valid;
  logic        flush_D;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .redirect_tgt (redirect_tgt),
    .imem_addr    (imem_addr),
    .imem_re      (imem_re),
    .imem_dout    (imem_dout),
    .D_pc         (D_pc),
    .D_inst       (D_inst),
    .D_valid      (D_valid),
    .flush_D      (flush_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (imem_re) imem_dout <= inst_of(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then apply this cycle's inputs; checks follow after settling.
  task automatic cyc(input logic rst, input logic [1:0] sel, input logic [31:0] tgt, input logic stl);
    @(posedge clk);
    #1;
    reset        = rst;
    pc_sel       = sel;
    redirect_tgt = tgt;
    stall        = stl;
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"},    D_pc, pc);
    chk({tag, "_inst"},  D_inst, inst_of(pc));
    chk({tag, "_valid"}, {31'd0, D_valid}, 32'd1);
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_inst"},  D_inst, NOP);
    chk({tag, "_valid"}, {31'd0, D_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 2'd0; redirect_tgt = 32'd0;

    // Reset for three cycles; pc_sel=1 in the last must not raise flush_D.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h0000_2100, 0);
    chk("rst_re",    {31'd0, imem_re}, 32'd0);
    chk("rst_flush", {31'd0, flush_D}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0000_2000);
    chk("rst_dpc",   D_pc, 32'h0000_2000);
    chk_nop("rst");

    // Fill and straight-line fetch.
    cyc(0, 0, 0, 0);
    chk_nop("fill1");
    chk("fill1_addr", imem_addr, 32'h0000_2000);
    chk("fill1_re",   {31'd0, imem_re}, 32'd1);
    cyc(0, 0, 0, 0);
    chk_run("c2", 32'h0000_2000);
    chk("c2_addr", imem_addr, 32'h0000_2004);
    cyc(0, 0, 0, 0);
    chk_run("c3", 32'h0000_2004);

    // Redirect at 0x2008.
    cyc(0, 1, 32'h0000_2100, 0);
    chk_run("redir", 32'h0000_2008);
    chk("redir_flush", {31'd0, flush_D}, 32'd1);
    cyc(0, 0, 0, 0);
    chk_nop("kill1");
    chk("kill1_flush", {31'd0, flush_D}, 32'd0);
    chk("kill1_addr", imem_addr, 32'h0000_2100);

    // pc_sel=2 from RUN.
    cyc(0, 2, 0, 0);
    chk_run("tgt1", 32'h0000_2100);
    chk("rsel_flush", {31'd0, flush_D}, 32'd1);
    cyc(0, 0, 0, 0);
    chk_nop("rsel_fill");
    chk("rsel_addr", imem_addr, 32'h0000_2000);
    cyc(0, 0, 0, 0);
    chk_run("rsel_a", 32'h0000_2000);
    cyc(0, 0, 0, 0);
    chk_run("rsel_b", 32'h0000_2004);
    cyc(0, 0, 0, 0);
    chk_run("rsel_c", 32'h0000_2008);

    // Three-cycle stall at 0x200C, held through the first released cycle.
    cyc(0, 0, 0, 1);
    chk_run("stl0", 32'h0000_200C);
    cyc(0, 0, 0, 1);
    chk_run("stl1", 32'h0000_200C);
    cyc(0, 0, 0, 1);
    chk_run("stl2", 32'h0000_200C);
    chk("stl2_addr", imem_addr, 32'h0000_2010);
    cyc(0, 0, 0, 0);
    chk_run("stl_rel", 32'h0000_200C);
    cyc(0, 0, 0, 0);
    chk_run("post1", 32'h0000_2010);
    cyc(0, 0, 0, 0);
    chk_run("post2", 32'h0000_2014);

    // Reset asserted mid-stall; hold data must not reappear.
    cyc(0, 0, 0, 1);
    chk_run("ms0", 32'h0000_2018);
    cyc(0, 0, 0, 1);
    chk_run("ms1", 32'h0000_2018);
    cyc(1, 0, 0, 1);
    chk_nop("ms_rst");
    chk("ms_rst_re", {31'd0, imem_re}, 32'd0);
    cyc(0, 0, 0, 0);
    chk_nop("ms_fill");
    chk("ms_fill_addr", imem_addr, 32'h0000_2000);
    cyc(0, 0, 0, 0);
    chk_run("ms_a", 32'h0000_2000);

    // Redirect together with stall.
    cyc(0, 1, 32'h0000_2200, 1);
    chk_run("rs", 32'h0000_2004);
    chk("rs_flush", {31'd0, flush_D}, 32'd1);
    cyc(0, 0, 0, 0);
    chk_nop("rs_kill");
    chk("rs_kill_addr", imem_addr, 32'h0000_2200);
    cyc(0, 0, 0, 0);
    chk_run("rs_tgt", 32'h0000_2200);

    // Back-to-back redirects.
    cyc(0, 1, 32'h0000_2100, 0);
    chk_run("bb", 32'h0000_2204);
    chk("bb_flush0", {31'd0, flush_D}, 32'd1);
    cyc(0, 1, 32'h0000_2300, 0);
    chk_nop("bb_k1");
    chk("bb_flush1", {31'd0, flush_D}, 32'd1);
    chk("bb_k1_addr", imem_addr, 32'h0000_2100);
    cyc(0, 0, 0, 0);
    chk_nop("bb_k2");
    chk("bb_k2_addr", imem_addr, 32'h0000_2300);
    cyc(0, 0, 0, 0);
    chk_run("bb_tgt", 32'h0000_2300);

    // Wrap past 2^32, with pc_sel=3 behaving as PC+4.
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    chk_run("wr0", 32'h0000_2304);
    cyc(0, 0, 0, 0);
    chk_nop("wr_kill");
    cyc(0, 3, 0, 0);
    chk_run("wr_top", 32'hFFFF_FFFC);
    chk("wr_addr", imem_addr, 32'h0000_0000);
    chk("sel3_flush", {31'd0, flush_D}, 32'd0);
    cyc(0, 0, 0, 0);
    chk_run("wr_zero", 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
